// File: rtl/vga_pkg.sv
// vga_pkg
// Shared definitions for the VGA timing path.
//   - DEF_* : default 640x480@60 timing constants (pixel clock = clk / DEF_DIV)
//   - pattern_t : identifiers of the downstream test-pattern generators
//   - sum4 / H_TOTAL / V_TOTAL : line and frame lengths in pixels / lines
package vga_pkg;

  localparam int DEF_DIV            = 4;
  localparam int DEF_H_VIS          = 640;
  localparam int DEF_H_FP           = 16;
  localparam int DEF_H_SYNC         = 96;
  localparam int DEF_H_BP           = 48;
  localparam int DEF_V_VIS          = 480;
  localparam int DEF_V_FP           = 10;
  localparam int DEF_V_SYNC         = 2;
  localparam int DEF_V_BP           = 33;
  localparam int DEF_FRAMES_PER_PAT = 120;

  typedef enum logic [1:0] {
    PAT_BARS  = 2'd0,
    PAT_RAMP  = 2'd1,
    PAT_GRID  = 2'd2,
    PAT_SOLID = 2'd3
  } pattern_t;

  function automatic int sum4(input int a, input int b, input int c, input int d);
    return a + b + c + d;
  endfunction

  localparam int H_TOTAL = sum4(DEF_H_VIS, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
  localparam int V_TOTAL = sum4(DEF_V_VIS, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

endpackage

// File: rtl/vga_timing_ctrl_pix_tick_gen.sv
// pix_tick_gen
// Divides the system clock into a one-clock-wide pixel-rate enable.
//   clk      : system clock
//   reset_n  : asynchronous active-low reset
//   pix_tick : high for one clock every DIV clocks (when the divider reads DIV-1)
module pix_tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  output logic pix_tick
);

  localparam int W = $clog2(DIV);
  localparam logic [W-1:0] DIV_LAST = W'(DIV - 1);

  logic [W-1:0] div_cnt_reg;
  logic [W-1:0] div_cnt_next;

  always_comb begin
    div_cnt_next = div_cnt_reg + W'(1);
    if (div_cnt_reg == DIV_LAST) begin
      div_cnt_next = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt_reg <= '0;
    end else begin
      div_cnt_reg <= div_cnt_next;
    end
  end

  assign pix_tick = (div_cnt_reg == DIV_LAST);

endmodule

// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl
// VGA pixel-timing sequencer and frame-synchronous test-pattern scheduler.
//   clk          : system clock
//   reset_n      : asynchronous active-low reset
//   auto_en      : cycle patterns automatically every FRAMES_PER_PAT frames
//   pattern_next : one-clock request to advance the pattern at the next frame wrap
//   pix_tick     : pixel-rate clock enable
//   h_sync       : horizontal sync, active-low
//   v_sync       : vertical sync, active-low
//   DE           : display enable (visible area)
//   x_pixel      : horizontal counter
//   y_pixel      : vertical counter
//   line_start   : one-clock pulse in the cycle the horizontal counter wraps
//   frame_start  : one-clock pulse in the cycle the whole frame wraps
//   pattern_sel  : active pattern (bars, ramp, grid, solid)
module vga_timing_ctrl
  import vga_pkg::*;
#(
  parameter int DIV            = DEF_DIV,
  parameter int H_VIS          = DEF_H_VIS,
  parameter int H_FP           = DEF_H_FP,
  parameter int H_SYNC         = DEF_H_SYNC,
  parameter int H_BP           = DEF_H_BP,
  parameter int V_VIS          = DEF_V_VIS,
  parameter int V_FP           = DEF_V_FP,
  parameter int V_SYNC         = DEF_V_SYNC,
  parameter int V_BP           = DEF_V_BP,
  parameter int FRAMES_PER_PAT = DEF_FRAMES_PER_PAT
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       auto_en,
  input  logic       pattern_next,
  output logic       pix_tick,
  output logic       h_sync,
  output logic       v_sync,
  output logic       DE,
  output logic [9:0] x_pixel,
  output logic [9:0] y_pixel,
  output logic       line_start,
  output logic       frame_start,
  output logic [1:0] pattern_sel
);

  localparam int HT = sum4(H_VIS, H_FP, H_SYNC, H_BP);
  localparam int VT = sum4(V_VIS, V_FP, V_SYNC, V_BP);
  localparam logic [9:0] H_LAST  = 10'(HT - 1);
  localparam logic [9:0] V_LAST  = 10'(VT - 1);
  localparam logic [6:0] FC_LAST = 7'(FRAMES_PER_PAT - 1);

  // Per-axis decode constants; index 0 = horizontal, 1 = vertical.
  localparam logic [1:0][9:0] VIS_LIM = {10'(V_VIS), 10'(H_VIS)};
  localparam logic [1:0][9:0] SYNC_LO = {10'(V_VIS + V_FP), 10'(H_VIS + H_FP)};
  localparam logic [1:0][9:0] SYNC_HI = {10'(V_VIS + V_FP + V_SYNC), 10'(H_VIS + H_FP + H_SYNC)};

  logic [9:0] h_cnt_reg, h_cnt_next;
  logic [9:0] v_cnt_reg, v_cnt_next;
  logic [6:0] frame_cnt_reg, frame_cnt_next;
  logic       pending_reg, pending_next;
  pattern_t   pat_reg, pat_next;
  logic       adv;

  logic [1:0][9:0] axis_cnt;
  logic [1:0]      axis_vis;
  logic [1:0]      axis_sync_n;

  pix_tick_gen #(
    .DIV (DIV)
  ) u_pix_tick_gen (
    .clk      (clk),
    .reset_n  (reset_n),
    .pix_tick (pix_tick)
  );

  // ---------------------------------------------------------------------
  // Horizontal / vertical counters
  // ---------------------------------------------------------------------
  assign line_start  = pix_tick && (h_cnt_reg == H_LAST);
  assign frame_start = line_start && (v_cnt_reg == V_LAST);

  always_comb begin
    h_cnt_next = h_cnt_reg;
    v_cnt_next = v_cnt_reg;
    if (pix_tick) begin
      if (h_cnt_reg == H_LAST) begin
        h_cnt_next = '0;
        v_cnt_next = (v_cnt_reg == V_LAST) ? '0 : v_cnt_reg + 10'd1;
      end else begin
        h_cnt_next = h_cnt_reg + 10'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt_reg <= '0;
      v_cnt_reg <= '0;
    end else begin
      h_cnt_reg <= h_cnt_next;
      v_cnt_reg <= v_cnt_next;
    end
  end

  // ---------------------------------------------------------------------
  // Sync / visible-area decode, identical structure on both axes
  // ---------------------------------------------------------------------
  assign axis_cnt = {v_cnt_reg, h_cnt_reg};

  for (genvar gi = 0; gi < 2; gi++) begin : g_axis
    assign axis_vis[gi]    = (axis_cnt[gi] < VIS_LIM[gi]);
    assign axis_sync_n[gi] = !((axis_cnt[gi] >= SYNC_LO[gi]) && (axis_cnt[gi] < SYNC_HI[gi]));
  end

  assign DE      = &axis_vis;
  assign h_sync  = axis_sync_n[0];
  assign v_sync  = axis_sync_n[1];
  assign x_pixel = h_cnt_reg;
  assign y_pixel = v_cnt_reg;

  // ---------------------------------------------------------------------
  // Pattern scheduler: all changes are confined to the frame_start cycle so
  // the selector never moves mid-frame. A request arriving in the
  // frame_start cycle itself is honoured immediately rather than latched,
  // and manual + auto in the same frame still advance only once.
  // ---------------------------------------------------------------------
  assign adv = pending_reg || pattern_next || (auto_en && (frame_cnt_reg == FC_LAST));

  always_comb begin
    pat_next       = pat_reg;
    frame_cnt_next = frame_cnt_reg;
    pending_next   = pending_reg || pattern_next;
    if (frame_start) begin
      pending_next = 1'b0;
      if (adv) begin
        pat_next       = pattern_t'(pat_reg + 2'd1);
        frame_cnt_next = '0;
      end else if (auto_en) begin
        frame_cnt_next = frame_cnt_reg + 7'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pat_reg       <= PAT_BARS;
      frame_cnt_reg <= '0;
      pending_reg   <= 1'b0;
    end else begin
      pat_reg       <= pat_next;
      frame_cnt_reg <= frame_cnt_next;
      pending_reg   <= pending_next;
    end
  end

  assign pattern_sel = pat_reg;

endmodule

// File: doc/vga_timing_ctrl.md
# vga_timing_ctrl

Pixel-timing sequencer and test-pattern scheduler for the VGA output path. Divides the system clock into a pixel-rate enable and runs horizontal/vertical counters. From those counters it generates `h_sync`, `v_sync`, `DE`, `x_pixel` and `y_pixel` for the downstream colour-generation blocks. It also owns `pattern_sel`, the frame-synchronous selector that chooses which pattern generator drives the RGB ports. Pattern changes take effect only at frame boundaries, so a frame never tears.

## Interface
Parameters:
- `DIV`, 4: system clocks per pixel; allowed range 2..16.
- `H_VIS`, 640: visible pixels per line.
- `H_FP`, 16: horizontal front porch, in pixels.
- `H_SYNC`, 96: horizontal sync width, in pixels.
- `H_BP`, 48: horizontal back porch, in pixels.
- `V_VIS`, 480: visible lines per frame.
- `V_FP`, 10: vertical front porch, in lines.
- `V_SYNC`, 2: vertical sync width, in lines.
- `V_BP`, 33: vertical back porch, in lines.
- `FRAMES_PER_PAT`, 120: frames shown per pattern in auto mode; must be ≥ 1.

Ports:
- `clk`  in  1  system clock (100 MHz).
- `reset_n`  in  1  reset; asynchronous assert, active-low.
- `auto_en`  in  1  enables automatic pattern cycling.
- `pattern_next`  in  1  one-clock request to advance the pattern.
- `pix_tick`  out  1  pixel-rate clock enable.
- `h_sync`  out  1  horizontal sync, active-low.
- `v_sync`  out  1  vertical sync, active-low.
- `DE`  out  1  display enable; high in the visible area.
- `x_pixel`  out  10  current horizontal count.
- `y_pixel`  out  10  current vertical count.
- `line_start`  out  1  one-clock pulse at each line wrap.
- `frame_start`  out  1  one-clock pulse at each frame wrap.
- `pattern_sel`  out  2  active pattern: 0 = colour bars, 1 = grey ramp, 2 = grid, 3 = solid.

## Operation
- Counter ranges: H_TOTAL = sum of the four H parameters (800 by default); V_TOTAL = sum of the four V parameters (525 by default).
- Pixel divider: `div_cnt` counts 0..DIV-1 and wraps. `pix_tick` = (`div_cnt` == DIV-1).
- `h_cnt` (0..H_TOTAL-1) increments on `pix_tick` and wraps to 0.
- `v_cnt` increments when `h_cnt` wraps, and itself wraps to 0 after V_TOTAL-1.
- All outputs except `pattern_sel` are combinational decodes of the registered counters:
  - `x_pixel` = `h_cnt`; `y_pixel` = `v_cnt`.
  - `DE` = (`h_cnt` < H_VIS) && (`v_cnt` < V_VIS).
  - `h_sync` = 0 iff H_VIS+H_FP ≤ `h_cnt` < H_VIS+H_FP+H_SYNC; `v_sync` is decoded the same way from `v_cnt` and the V parameters.
  - `line_start` = `pix_tick` && `h_cnt` == H_TOTAL-1.
  - `frame_start` = `line_start` && `v_cnt` == V_TOTAL-1.
- Pattern scheduler, registered state: `pattern_sel`, `frame_cnt` (7 bits wide; must hold FRAMES_PER_PAT-1), and a `pending` flag.
  - A `pattern_next` pulse sets `pending`.
  - The advance condition at `frame_start` is `adv` = `pending` || `pattern_next` || (`auto_en` && `frame_cnt` == FRAMES_PER_PAT-1).
  - If `adv` is true: `pattern_sel` += 1 (3 wraps to 0), `frame_cnt` ← 0, `pending` ← 0. Simultaneous manual and auto causes exactly one advance.
  - If `adv` is false at `frame_start`: `frame_cnt` += 1 when `auto_en`, otherwise `frame_cnt` holds.
  - Deasserting `auto_en` freezes `frame_cnt`; the count is not cleared.
- Multiple `pattern_next` pulses within one frame collapse into a single advance.

## Timing
- Reset values (async, on `reset_n` = 0):
  - `div_cnt`, `h_cnt`, `v_cnt`, `frame_cnt`, `pending`, `pattern_sel` all = 0.
  - Resulting outputs: `DE` = 1, `h_sync` = 1, `v_sync` = 1, `x_pixel` = `y_pixel` = 0, `pix_tick` = `line_start` = `frame_start` = 0.
- The first `pix_tick` is asserted on the DIV-th rising edge after reset release.
- Counter outputs have zero latency from the counter registers. `pattern_sel` changes on the edge that ends the `frame_start` cycle, which is the same edge on which `h_cnt` and `v_cnt` go to 0.
- Frame period is DIV × H_TOTAL × V_TOTAL clocks (1,680,000 at defaults).
- Reset mid-frame: all state returns to the reset values immediately, and `pending` is lost.

## Structure
- Package `vga_pkg`:
  - default timing constants;
  - `pattern_t` enum (`PAT_BARS`, `PAT_RAMP`, `PAT_GRID`, `PAT_SOLID`);
  - `H_TOTAL` / `V_TOTAL` helper localparams.
- Sub-module `pix_tick_gen` (parameter `DIV`): contains the divider counter and drives `pix_tick`.
- The remainder lives in `vga_timing_ctrl`: counters, decode and scheduler.

## Test plan
- Reset with defaults, then release: `pix_tick` fires at clocks 4, 8, 12…; `line_start` fires at clock 3200; `frame_start` fires at clock 1,680,000.
- Sync and DE windows at defaults: `h_sync` low for `h_cnt` 656..751; `v_sync` low for `v_cnt` 490..491; `DE` low at `h_cnt` = 640 and at `v_cnt` = 480.
- Reduced timing (DIV=2, H=4/1/1/1, V=3/1/1/1, FRAMES_PER_PAT=2) with `auto_en` = 1: `pattern_sel` steps 0→1→2→3→0 every 2 frames.
- `pattern_next` pulsed mid-frame with `auto_en` = 0: `pattern_sel` changes only at the next `frame_start`. Three pulses within one frame give a single increment.
- `pattern_next` asserted in the same cycle as an auto-advance `frame_start`: exactly one increment, `frame_cnt` = 0 afterwards.
- Assert `reset_n` mid-line at `h_cnt` = 300, `pattern_sel` = 2: all counters and `pattern_sel` read 0 immediately, without waiting for a clock edge.
